// File: rtl/pipe_pkg.sv
// Shared widths, types and helpers for the elastic pipeline stage.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_W_DEF  = 5;

  // Beats held by one stage: 0, 1 or 2.
  typedef logic [1:0] occ_t;

  // Control FSM state; the encoding equals the number of beats held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HEAD  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  // Width of a flat bundle of n fields, each w bits wide.
  function automatic int unsigned bundle_w(input int unsigned n, input int unsigned w);
    return n * w;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// One storage slot of the stage: valid flag plus control, data and register payload.
// Clear drops the beat and zeroes its control bundle; load captures a new beat.
module pipe_stage_skid_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = 8,
  parameter int DATA_W   = int'(DATA_W_DEF),
  parameter int NUM_DATA = 4,
  parameter int REG_W    = int'(REG_W_DEF),
  parameter int NUM_REGS = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 load_i,
  input  logic                                 clear_i,
  input  logic [CTRL_W-1:0]                    ctrl_i,
  input  logic [bundle_w(NUM_DATA, DATA_W)-1:0] data_i,
  input  logic [bundle_w(NUM_REGS, REG_W)-1:0]  regs_i,
  output logic                                 valid_o,
  output logic [CTRL_W-1:0]                    ctrl_o,
  output logic [bundle_w(NUM_DATA, DATA_W)-1:0] data_o,
  output logic [bundle_w(NUM_REGS, REG_W)-1:0]  regs_o
);

  logic                                 valid_q;
  logic [CTRL_W-1:0]                    ctrl_q;
  logic [bundle_w(NUM_DATA, DATA_W)-1:0] data_q;
  logic [bundle_w(NUM_REGS, REG_W)-1:0]  regs_q;

  // Slot register: clear wins over load so a flush always leaves a bubble.
  // NOTE: the payload is reset too, because the head slot drives the stage outputs
  // directly and those must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values regardless of evaluation order.
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      regs_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
      regs_q  <= regs_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;
  assign regs_o  = regs_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic inter-stage pipeline register with a 2-entry skid buffer, synchronous
// flush (bubble insertion) and a saturating stall counter. in_ready depends on
// registered state only, so no combinational path runs from out_ready to in_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = 8,
  parameter int DATA_W   = int'(DATA_W_DEF),
  parameter int NUM_DATA = 4,
  parameter int REG_W    = int'(REG_W_DEF),
  parameter int NUM_REGS = 3,
  parameter int CNT_W    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [CTRL_W-1:0]                    in_ctrl,
  input  logic [bundle_w(NUM_DATA, DATA_W)-1:0] in_data,
  input  logic [bundle_w(NUM_REGS, REG_W)-1:0]  in_regs,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [CTRL_W-1:0]                    out_ctrl,
  output logic [bundle_w(NUM_DATA, DATA_W)-1:0] out_data,
  output logic [bundle_w(NUM_REGS, REG_W)-1:0]  out_regs,
  output occ_t                                 occupancy,
  output logic [CNT_W-1:0]                     stall_cnt
);

  localparam int unsigned DBUS_W = bundle_w(NUM_DATA, DATA_W);
  localparam int unsigned RBUS_W = bundle_w(NUM_REGS, REG_W);

  stage_state_e state_q, state_d;

  logic              head_v, skid_v;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
  logic [DBUS_W-1:0] head_data, skid_data;
  logic [RBUS_W-1:0] head_regs, skid_regs;

  logic              head_load, head_clear, head_from_skid;
  logic              skid_load, skid_clear;
  logic [CTRL_W-1:0] head_ctrl_in;
  logic [DBUS_W-1:0] head_data_in;
  logic [RBUS_W-1:0] head_regs_in;

  logic              accept, send;
  logic [CNT_W-1:0]  stall_q;

  assign in_ready = !skid_v;
  assign accept   = in_valid & in_ready;
  assign send     = head_v & out_ready;

  // Slot strobes and next state; flush overrides accept and send.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // value unassigned and no latch is inferred.
    head_load      = 1'b0;
    head_clear     = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    state_d        = state_q;
    if (flush) begin
      head_clear = 1'b1;
      skid_clear = 1'b1;
      state_d    = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_load = 1'b1;
            state_d   = ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (accept && send) begin
            head_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end else if (send) begin
            head_clear = 1'b1;
            state_d    = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (send) begin
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = ST_HEAD;
          end
        end
        default: begin
          head_clear = 1'b1;
          skid_clear = 1'b1;
          state_d    = ST_EMPTY;
        end
      endcase
    end
  end

  // Head refills from the skid slot when it holds a beat, otherwise from upstream.
  always_comb begin
    head_ctrl_in = in_ctrl;
    head_data_in = in_data;
    head_regs_in = in_regs;
    if (head_from_skid) begin
      head_ctrl_in = skid_ctrl;
      head_data_in = skid_data;
      head_regs_in = skid_regs;
    end
  end

  // Control FSM register; its encoding is the occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Stall counter: counts cycles the head beat is blocked, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (head_v && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  pipe_stage_skid_entry #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA),
    .REG_W(REG_W), .NUM_REGS(NUM_REGS)
  ) u_head (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (head_load),
    .clear_i(head_clear),
    .ctrl_i (head_ctrl_in),
    .data_i (head_data_in),
    .regs_i (head_regs_in),
    .valid_o(head_v),
    .ctrl_o (head_ctrl),
    .data_o (head_data),
    .regs_o (head_regs)
  );

  pipe_stage_skid_entry #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA),
    .REG_W(REG_W), .NUM_REGS(NUM_REGS)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (skid_load),
    .clear_i(skid_clear),
    .ctrl_i (in_ctrl),
    .data_i (in_data),
    .regs_i (in_regs),
    .valid_o(skid_v),
    .ctrl_o (skid_ctrl),
    .data_o (skid_data),
    .regs_o (skid_regs)
  );

  // The head slot zeroes its control bundle whenever it is invalid, so out_ctrl is a bubble.
  assign out_valid = head_v;
  assign out_ctrl  = head_ctrl;
  assign out_data  = head_data;
  assign out_regs  = head_regs;
  assign occupancy = occ_t'(state_q);
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench: a queue-of-beats reference model (capacity 2) feeds a
// scoreboard; the monitor pops and compares each beat the DUT hands downstream.
module tb_pipe_stage_skid;

  localparam int CTRL_W   = 8;
  localparam int DATA_W   = 32;
  localparam int NUM_DATA = 4;
  localparam int REG_W    = 5;
  localparam int NUM_REGS = 3;
  localparam int CNT_W    = 4;
  localparam int DW       = DATA_W * NUM_DATA;
  localparam int RW       = REG_W * NUM_REGS;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DW-1:0]     data;
    logic [RW-1:0]     regs;
  } beat_t;

  logic              clk, rst_n, flush;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0]     in_data, out_data;
  logic [RW-1:0]     in_regs, out_regs;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  beat_t       exp_q[$];
  int unsigned stall_m;
  bit          last_acc;
  int          checks, errors;

  pipe_stage_skid #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA),
    .REG_W(REG_W), .NUM_REGS(NUM_REGS), .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .in_regs  (in_regs),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .out_regs (out_regs),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=accept t=%0t", name, $time);
  endtask

  function automatic beat_t rand_beat(input int k);
    beat_t b;
    b.ctrl = CTRL_W'($urandom);
    for (int j = 0; j < NUM_DATA; j++) b.data[j*DATA_W +: DATA_W] = $urandom;
    b.data[0 +: DATA_W] = DATA_W'(k);
    b.regs = RW'($urandom);
    return b;
  endfunction

  task automatic set_in(input bit v, input beat_t b);
    in_valid = v;
    in_ctrl  = b.ctrl;
    in_data  = b.data;
    in_regs  = b.regs;
  endtask

  // Offer a beat from the current negedge until the model says it was taken.
  task automatic push_beat(input beat_t b, input int max_cyc);
    bit took;
    took = 1'b0;
    set_in(1'b1, b);
    for (int c = 0; c < max_cyc && !took; c++) begin
      @(negedge clk);
      took = last_acc;
    end
    if (!took) timeout_fail("push_beat");
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge arrives.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    exp_q.delete();
    stall_m  = 0;
    last_acc = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl",  out_ctrl, 0);
    check("rst_out_data",  out_data, 0);
    check("rst_out_regs",  out_regs, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_in_ready",  in_ready, 1);
    set_in(1'b1, rand_beat(99));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    set_in(1'b0, rand_beat(0));
    check("post_rst_in_ready", in_ready, 1);
  endtask

  // Scoreboard: monitor half pops on each DUT send; model half tracks accepts and stalls.
  always @(posedge clk) begin : sb
    int sz;
    if (rst_n) begin
      sz = exp_q.size();
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          check("send_unexpected", out_valid, 0);
        end else begin
          check("beat_ctrl", out_ctrl, exp_q[0].ctrl);
          check("beat_data", out_data, exp_q[0].data);
          check("beat_regs", out_regs, exp_q[0].regs);
          void'(exp_q.pop_front());
        end
      end
      last_acc = 1'b0;
      if (sz > 0 && !out_ready && stall_m < STALL_MAX) stall_m++;
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && sz < 2) begin
        exp_q.push_back(beat_t'{in_ctrl, in_data, in_regs});
        last_acc = 1'b1;
      end
    end
  end

  // Status checks away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", out_valid, (exp_q.size() > 0));
      check("occupancy", occupancy, exp_q.size());
      check("in_ready",  in_ready, (exp_q.size() < 2));
      check("stall_cnt", stall_cnt, stall_m);
      if (exp_q.size() > 0) begin
        check("head_ctrl", out_ctrl, exp_q[0].ctrl);
        check("head_data", out_data, exp_q[0].data);
        check("head_regs", out_regs, exp_q[0].regs);
      end else begin
        check("bubble_ctrl", out_ctrl, 0);
      end
    end
  end

  initial begin
    beat_t b;
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    flush  = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, '0);
    do_reset();

    // Streaming: beats 0..9 back to back, first beat one cycle after accept.
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push_beat(rand_beat(k), 5);
      if (k == 0) check("stream_first_valid", out_valid, 1);
    end
    set_in(1'b0, rand_beat(0));
    repeat (3) @(negedge clk);

    // Bubble: junk control with no valid beat never reaches out_ctrl.
    b = rand_beat(0);
    b.ctrl = 8'hFF;
    set_in(1'b0, b);
    repeat (3) @(negedge clk);
    check("bubble_ff_ctrl",  out_ctrl, 0);
    check("bubble_ff_valid", out_valid, 0);

    // Backpressure: A held, B in skid, C refused until out_ready returns.
    out_ready = 1'b0;
    push_beat(rand_beat(100), 3);
    push_beat(rand_beat(101), 3);
    set_in(1'b1, rand_beat(102));
    repeat (4) @(negedge clk);
    check("bp_c_refused", last_acc, 0);
    check("bp_in_ready",  in_ready, 0);
    check("bp_occ",       occupancy, 2);
    check("bp_stall_nz",  (stall_cnt != 0), 1);
    out_ready = 1'b1;
    push_beat(rand_beat(102), 6);
    set_in(1'b0, rand_beat(0));
    repeat (4) @(negedge clk);
    check("bp_drained", out_valid, 0);

    // Flush with a full stage and an incoming beat.
    out_ready = 1'b0;
    push_beat(rand_beat(200), 3);
    push_beat(rand_beat(201), 3);
    flush = 1'b1;
    set_in(1'b1, rand_beat(202));
    @(negedge clk);
    flush = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_ctrl",  out_ctrl, 0);
    check("flush_occ",   occupancy, 0);
    out_ready = 1'b1;
    push_beat(rand_beat(203), 3);
    check("flush_next_valid", out_valid, 1);
    check("flush_next_data",  out_data[DATA_W-1:0], 203);
    set_in(1'b0, rand_beat(0));
    repeat (3) @(negedge clk);

    // Reset mid-stream with two beats held.
    out_ready = 1'b0;
    push_beat(rand_beat(300), 3);
    push_beat(rand_beat(301), 3);
    check("pre_rst_occ", occupancy, 2);
    do_reset();

    // Saturation: one blocked beat for 20 cycles.
    out_ready = 1'b0;
    push_beat(rand_beat(400), 3);
    set_in(1'b0, rand_beat(0));
    repeat (20) @(negedge clk);
    check("sat_stall", stall_cnt, STALL_MAX);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("sat_hold", stall_cnt, STALL_MAX);

    // Randomised traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      set_in(($urandom_range(0, 3) != 0), rand_beat(500 + c));
      @(negedge clk);
    end
    flush = 1'b0;
    out_ready = 1'b1;
    set_in(1'b0, rand_beat(0));
    repeat (5) @(negedge clk);
    check("final_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
